// File: rtl/seq_dwc_pkg.sv
// rtl/seq_dwc_pkg.sv - shared bounds and helpers for the duplicated-with-comparison AND pipeline
package seq_dwc_pkg;

    localparam int DEPTH_MIN   = 1;
    localparam int DEPTH_MAX   = 8;
    localparam int COUNT_W_MIN = 1;
    localparam int COUNT_W_MAX = 31;

    function automatic int max_count(input int count_w);
        return (1 << count_w) - 1;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
    endfunction

    function automatic bit count_w_ok(input int count_w);
        return (count_w >= COUNT_W_MIN) && (count_w <= COUNT_W_MAX);
    endfunction

endpackage

// File: rtl/seq_dwc_and_pipe_copy.sv
// rtl/seq_dwc_and_pipe_copy.sv - one independent AND gate plus valid/data shift pipeline
import seq_dwc_pkg::*;

module dwc_pipe_copy #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);

    // Kept so the two copies are never merged into one register set.
    (* keep = "true" *) logic [DEPTH-1:0]            valid_q;
    (* keep = "true" *) logic [DEPTH-1:0][WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q[0] <= valid_in;
            data_q[0]  <= in_a & in_b;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_out = valid_q[DEPTH-1];
    assign data_out  = data_q[DEPTH-1];

endmodule

// File: rtl/seq_dwc_and_pipe.sv
// rtl/seq_dwc_and_pipe.sv - two-copy pipelined AND with last-stage comparison and error reporting
import seq_dwc_pkg::*;

module seq_dwc_and_pipe #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 2,
    parameter int COUNT_W = 4,
    parameter bit STICKY  = 1'b1
) (
    input  logic               port_clk,
    input  logic               port_rst,
    input  logic               port_valid_in,
    input  logic [WIDTH-1:0]   port_in_0,
    input  logic [WIDTH-1:0]   port_in_1,
    input  logic               port_clear,
    output logic               port_valid_out,
    output logic [WIDTH-1:0]   port_out,
    output logic               port_error,
    output logic [WIDTH-1:0]   port_error_bits,
    output logic               port_error_flag,
    output logic [COUNT_W-1:0] port_error_count
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("seq_dwc_and_pipe: DEPTH out of range");
    end
    if (!count_w_ok(COUNT_W)) begin : g_bad_count_w
        $error("seq_dwc_and_pipe: COUNT_W out of range");
    end

    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(max_count(COUNT_W));

    wire             v0;
    wire             v1;
    wire [WIDTH-1:0] d0;
    wire [WIDTH-1:0] d1;

    dwc_pipe_copy #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_copy_0 (
        .clk       (port_clk),
        .rst       (port_rst),
        .valid_in  (port_valid_in),
        .in_a      (port_in_0),
        .in_b      (port_in_1),
        .valid_out (v0),
        .data_out  (d0)
    );

    dwc_pipe_copy #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_copy_1 (
        .clk       (port_clk),
        .rst       (port_rst),
        .valid_in  (port_valid_in),
        .in_a      (port_in_0),
        .in_b      (port_in_1),
        .valid_out (v1),
        .data_out  (d1)
    );

    // Data differences only matter when at least one copy claims a valid item.
    assign port_error_bits = (v0 | v1) ? (d0 ^ d1) : '0;
    assign port_error      = (v0 ^ v1) | (|port_error_bits);

    assign port_valid_out  = v0;
    assign port_out        = d0;

    if (STICKY) begin : g_flag_sticky
        always_ff @(posedge port_clk or posedge port_rst) begin
            if (port_rst) port_error_flag <= 1'b0;
            else          port_error_flag <= port_error | (port_error_flag & ~port_clear);
        end
    end else begin : g_flag_live
        always_ff @(posedge port_clk or posedge port_rst) begin
            if (port_rst) port_error_flag <= 1'b0;
            else          port_error_flag <= port_error;
        end
    end

    always_ff @(posedge port_clk or posedge port_rst) begin
        if (port_rst) begin
            port_error_count <= '0;
        end else if (port_clear) begin
            port_error_count <= port_error ? COUNT_W'(1) : '0;
        end else if (port_error && (port_error_count != COUNT_MAX)) begin
            port_error_count <= port_error_count + COUNT_W'(1);
        end
    end

endmodule
